serial_adder: RTL



---
 rtl/serial_adder_pkg.sv | 12 +
 rtl/full_adder_cell.sv | 13 +
 rtl/serial_adder.sv | 112 +++++++++++
 3 files changed

// File: rtl/serial_adder_pkg.sv
// Shared types and limits for the bit-serial adder.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int WIDTH_MAX = 32;

endpackage

// File: rtl/full_adder_cell.sv
// Single-bit combinational full adder shared by every bit position of the serial adder.
module full_adder_cell (
    input  logic a,
    input  logic b,
    input  logic c_in,
    output logic sum,
    output logic c_out
);

    assign sum   = a ^ b ^ c_in;
    assign c_out = (a & b) | (a & c_in) | (b & c_in);

endmodule

// File: rtl/serial_adder.sv
// WIDTH-bit serial adder: one bit per clock through one full-adder cell, start/busy/done handshake.
// Optional subtract mode (sub port) is built when SERIAL_ADDER_SUB_EN is defined.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             busy,
    output logic             done
);

    state_t             state, state_nxt;
    logic [WIDTH-1:0]   a_sr, b_sr, sum_r;
    logic [WIDTH-1:0]   b_load;
    logic [CNT_W-1:0]   cnt;
    logic               carry, c_init;
    logic               cout_r, ovf_r;
    logic               fa_s, fa_c;
    logic               last_bit;

`ifdef SERIAL_ADDER_SUB_EN
    // Subtraction as a + ~b + 1: invert B and seed the carry chain with 1.
    assign b_load = sub ? ~b : b;
    assign c_init = sub;
`else
    assign b_load = b;
    assign c_init = 1'b0;
`endif

    assign last_bit = (cnt == CNT_W'(WIDTH - 1));

    full_adder_cell u_fa (
        .a     (a_sr[0]),
        .b     (b_sr[0]),
        .c_in  (carry),
        .sum   (fa_s),
        .c_out (fa_c)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (last_bit) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_sr   <= '0;
            b_sr   <= '0;
            sum_r  <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            cout_r <= 1'b0;
            ovf_r  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sr   <= a;
                        b_sr   <= b_load;
                        carry  <= c_init;
                        cnt    <= '0;
                        sum_r  <= '0;
                        cout_r <= 1'b0;
                        ovf_r  <= 1'b0;
                    end
                end
                RUN: begin
                    sum_r <= {fa_s, sum_r[WIDTH-1:1]};
                    a_sr  <= a_sr >> 1;
                    b_sr  <= b_sr >> 1;
                    carry <= fa_c;
                    cnt   <= cnt + CNT_W'(1);
                    // On the MSB, 'carry' is still the carry into the MSB.
                    if (last_bit) begin
                        cout_r <= fa_c;
                        ovf_r  <= carry ^ fa_c;
                    end
                end
                default: ;
            endcase
        end
    end

    assign sum  = sum_r;
    assign cout = cout_r;
    assign ovf  = ovf_r;
    assign busy = (state == RUN);
    assign done = (state == DONE);

endmodule
